// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and default geometry for the IFU memory-side responder.
`ifndef VALID
`define VALID 1'b1
`endif

package ifu_pkg;

  localparam int DEF_TAG_WIDTH    = 28;
  localparam int DEF_OFFSET_WIDTH = 4;
  localparam int DEF_LINE_WIDTH   = 128;
  localparam int DEF_WORD_WIDTH   = 32;
  localparam int DEF_ADDR_WIDTH   = 32;

  // Line geometry at the default parameters.
  localparam int WORDS_PER_LINE = DEF_LINE_WIDTH / DEF_WORD_WIDTH;
  localparam int WORD_IDX_WIDTH = $clog2(WORDS_PER_LINE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_RESP,
    S_HOLD
  } resp_state_t;

endpackage

// File: rtl/ifu_line_assembler.sv
// ifu_line_assembler: collects memory words into a cache line, word 0 in the LSBs.
module ifu_line_assembler #(
  parameter int WORD_WIDTH = 32,
  parameter int WORDS      = 4,
  parameter int CNT_W      = $clog2(WORDS) + 1,
  parameter int LINE_WIDTH = WORD_WIDTH * WORDS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  wr_i,
  input  logic [WORD_WIDTH-1:0] data_i,
  output logic [LINE_WIDTH-1:0] line_o,
  output logic                  done_o
);

  localparam int IDX_W = $clog2(WORDS);
  localparam logic [CNT_W-1:0] WORDS_C = CNT_W'(WORDS);

  logic [CNT_W-1:0]      ret_cnt_q, ret_cnt_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic [IDX_W-1:0]      ret_idx;
  logic                  we;

  // Returns beyond a full line are dropped so a stray word cannot corrupt it.
  assign we      = wr_i && (ret_cnt_q < WORDS_C);
  assign done_o  = we && (ret_cnt_q == WORDS_C - CNT_W'(1));
  assign ret_idx = ret_cnt_q[IDX_W-1:0];
  assign line_o  = line_q;

  // Next-state for the return counter and the word slot addressed by it.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    line_d    = line_q;
    ret_cnt_d = ret_cnt_q;
    if (clr_i) begin
      ret_cnt_d = '0;
    end else if (we) begin
      line_d[ret_idx*WORD_WIDTH +: WORD_WIDTH] = data_i;
      ret_cnt_d = ret_cnt_q + CNT_W'(1);
    end
  end

  // Line buffer and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the buffer is a flop array that feeds the response outputs, so it is cleared on reset.
      line_q    <= '0;
      ret_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      line_q    <= line_d;
      ret_cnt_q <= ret_cnt_d;
    end
  end

endmodule

// File: rtl/ifu_mem_responder.sv
// ifu_mem_responder: fetches a cache line word-by-word from instruction memory
// and returns it to the IFU miss port as a single-cycle response.
module ifu_mem_responder
  import ifu_pkg::*;
#(
  parameter int TAG_WIDTH    = DEF_TAG_WIDTH,
  parameter int OFFSET_WIDTH = DEF_OFFSET_WIDTH,
  parameter int LINE_WIDTH   = DEF_LINE_WIDTH,
  parameter int WORD_WIDTH   = DEF_WORD_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH
) (
  input  logic                  Clock,
  input  logic                  Rst,
  input  logic [TAG_WIDTH-1:0]  mem_reqTagIn,
  input  logic                  mem_reqTagValidIn,
  output logic [TAG_WIDTH-1:0]  mem_rspTagOut,
  output logic [LINE_WIDTH-1:0] mem_rspInsLineOut,
  output logic                  mem_rspInsLineValidOut,
  output logic                  imem_rdReqOut,
  output logic [ADDR_WIDTH-1:0] imem_rdAddrOut,
  input  logic [WORD_WIDTH-1:0] imem_rdDataIn,
  input  logic                  imem_rdValidIn,
  output logic                  busy
);

  localparam int WORDS  = LINE_WIDTH / WORD_WIDTH;
  localparam int IDX_W  = $clog2(WORDS);
  localparam int CNT_W  = IDX_W + 1;
  localparam int BYTE_W = OFFSET_WIDTH - IDX_W;
  localparam logic [CNT_W-1:0] WORDS_C = CNT_W'(WORDS);

  resp_state_t           state_q, state_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [CNT_W-1:0]      issue_cnt_q, issue_cnt_d;
  logic [TAG_WIDTH-1:0]  rsp_tag_q, rsp_tag_d;
  logic [LINE_WIDTH-1:0] rsp_line_q, rsp_line_d;
  logic [LINE_WIDTH-1:0] line_buf;
  logic                  accept, issue_en, line_done;

  // The request is only looked at in IDLE; changes during a fetch are ignored.
  assign accept   = (state_q == S_IDLE) && (mem_reqTagValidIn == `VALID);
  assign issue_en = (state_q == S_FETCH) && (issue_cnt_q < WORDS_C);

  ifu_line_assembler #(
    .WORD_WIDTH (WORD_WIDTH),
    .WORDS      (WORDS),
    .CNT_W      (CNT_W),
    .LINE_WIDTH (LINE_WIDTH)
  ) u_line_assembler (
    .clk    (Clock),
    .rst    (Rst),
    .clr_i  (accept),
    .wr_i   ((state_q == S_FETCH) && imem_rdValidIn),
    .data_i (imem_rdDataIn),
    .line_o (line_buf),
    .done_o (line_done)
  );

  // State register.
  always_ff @(posedge Clock) begin
    if (Rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: fetch until the last word lands, then one RESP and one HOLD cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_FETCH;
      S_FETCH: if (line_done) state_d = S_RESP;
      S_RESP:  state_d = S_HOLD;
      S_HOLD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: read port while words remain to issue; response muxes in the live line during RESP.
  always_comb begin
    imem_rdReqOut          = 1'b0;
    imem_rdAddrOut         = '0;
    mem_rspInsLineValidOut = 1'b0;
    mem_rspTagOut          = rsp_tag_q;
    mem_rspInsLineOut      = rsp_line_q;
    busy                   = (state_q != S_IDLE);
    if (issue_en) begin
      imem_rdReqOut  = 1'b1;
      imem_rdAddrOut = {tag_q, issue_cnt_q[IDX_W-1:0], {BYTE_W{1'b0}}};
    end
    if (state_q == S_RESP) begin
      mem_rspInsLineValidOut = 1'b1;
      mem_rspTagOut          = tag_q;
      mem_rspInsLineOut      = line_buf;
    end
  end

  // Datapath next-state: tag capture, issue counter, and held copy of the last response.
  always_comb begin
    tag_d       = tag_q;
    issue_cnt_d = issue_cnt_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_line_d  = rsp_line_q;
    if (accept) begin
      tag_d       = mem_reqTagIn;
      issue_cnt_d = '0;
    end else if (issue_en) begin
      issue_cnt_d = issue_cnt_q + CNT_W'(1);
    end
    if (state_q == S_RESP) begin
      rsp_tag_d  = tag_q;
      rsp_line_d = line_buf;
    end
  end

  // Datapath registers.
  always_ff @(posedge Clock) begin
    if (Rst) begin
      tag_q       <= '0;
      issue_cnt_q <= '0;
      rsp_tag_q   <= '0;
      rsp_line_q  <= '0;
    end else begin
      tag_q       <= tag_d;
      issue_cnt_q <= issue_cnt_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_line_q  <= rsp_line_d;
    end
  end

endmodule

// File: tb/tb_ifu_mem_responder.sv
// tb_ifu_mem_responder: drives the miss port and a latency-programmable memory model,
// and checks responses against lines computed from the bench's own memory contents.
module tb_ifu_mem_responder;

  localparam int TW = 28;
  localparam int LW = 128;
  localparam int WW = 32;
  localparam int AW = 32;
  localparam logic [LW-1:0] BASIC_LINE = 128'h000000A3_000000A2_000000A1_000000A0;

  logic          Clock = 1'b0;
  logic          Rst;
  logic [TW-1:0] mem_reqTagIn;
  logic          mem_reqTagValidIn;
  logic [TW-1:0] mem_rspTagOut;
  logic [LW-1:0] mem_rspInsLineOut;
  logic          mem_rspInsLineValidOut;
  logic          imem_rdReqOut;
  logic [AW-1:0] imem_rdAddrOut;
  logic [WW-1:0] imem_rdDataIn = '0;
  logic          imem_rdValidIn = 1'b0;
  logic          busy;

  ifu_mem_responder dut (
    .Clock                  (Clock),
    .Rst                    (Rst),
    .mem_reqTagIn           (mem_reqTagIn),
    .mem_reqTagValidIn      (mem_reqTagValidIn),
    .mem_rspTagOut          (mem_rspTagOut),
    .mem_rspInsLineOut      (mem_rspInsLineOut),
    .mem_rspInsLineValidOut (mem_rspInsLineValidOut),
    .imem_rdReqOut          (imem_rdReqOut),
    .imem_rdAddrOut         (imem_rdAddrOut),
    .imem_rdDataIn          (imem_rdDataIn),
    .imem_rdValidIn         (imem_rdValidIn),
    .busy                   (busy)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;

  // Memory model state. Only the memory process writes cyc/reads/rets/pq/addr_log.
  typedef struct {
    logic [31:0] addr;
    int unsigned ready;
  } pend_t;

  pend_t       pq[$];
  logic [31:0] addr_log[$];
  logic [31:0] mem[logic [31:0]];
  int unsigned cyc = 0, reads = 0, rets = 0, last_ret_cyc = 0, last_ready = 0;
  int unsigned base_lat = 1;
  int unsigned gap_tab[4] = '{0, 0, 0, 0};
  int unsigned gap_gen = 0, gap_seen = 0, gap_idx = 0;
  int unsigned inj_req = 0, inj_done = 0;
  logic [31:0] inj_data = '0;
  int unsigned rsp_pulses = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Expected line: the four words at the line's byte addresses, word 0 lowest.
  function automatic logic [LW-1:0] exp_line(input logic [TW-1:0] tag);
    logic [LW-1:0] l;
    for (int i = 0; i < LW / WW; i++) l[WW*i +: WW] = mem_word({tag, 4'h0} + 32'(4 * i));
    return l;
  endfunction

  // Memory: in-order returns, each no earlier than base_lat after its read and
  // optionally gap_tab[i] idle cycles after the previous return.
  always begin
    int unsigned r, g;
    @(posedge Clock);
    #2;
    cyc++;
    if (inj_req != inj_done) begin
      inj_done       = inj_req;
      imem_rdValidIn = 1'b1;
      imem_rdDataIn  = inj_data;
    end else if (pq.size() > 0 && pq[0].ready <= cyc) begin
      imem_rdValidIn = 1'b1;
      imem_rdDataIn  = mem_word(pq[0].addr);
      void'(pq.pop_front());
      rets++;
      last_ret_cyc = cyc;
    end else begin
      imem_rdValidIn = 1'b0;
      imem_rdDataIn  = $urandom;
    end
    if (imem_rdReqOut === 1'b1) begin
      if (gap_gen != gap_seen) begin
        gap_seen = gap_gen;
        gap_idx  = 0;
      end
      g = 0;
      if (gap_idx < 4) begin
        g = gap_tab[gap_idx];
        gap_idx++;
      end
      r = cyc + base_lat;
      if (last_ready + 1 > r) r = last_ready + 1;
      r = r + g;
      last_ready = r;
      pq.push_back('{imem_rdAddrOut, r});
      addr_log.push_back(imem_rdAddrOut);
      reads++;
    end
  end

  // Response pulse counter, sampled mid-cycle.
  always begin
    @(posedge Clock);
    #3;
    if (mem_rspInsLineValidOut === 1'b1) rsp_pulses++;
  end

  task automatic set_timing(input int unsigned lat, input int unsigned g0, input int unsigned g1,
                            input int unsigned g2, input int unsigned g3);
    base_lat   = lat;
    gap_tab[0] = g0;
    gap_tab[1] = g1;
    gap_tab[2] = g2;
    gap_tab[3] = g3;
    gap_gen++;
  endtask

  task automatic wait_rsp(input int bound, output bit got);
    got = 1'b0;
    for (int k = 0; k < bound && !got; k++) begin
      @(negedge Clock);
      if (mem_rspInsLineValidOut === 1'b1) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    mem_reqTagValidIn = 1'b0;
    mem_reqTagIn = '0;
    repeat (3) @(negedge Clock);
    total++;
    if ({mem_rspInsLineValidOut, imem_rdReqOut, busy} !== 3'b000) begin
      bad++;
      $display("FAIL reset_ctrl: valid/rdreq/busy=%b expected 000", {mem_rspInsLineValidOut, imem_rdReqOut, busy});
    end
    total++;
    if (mem_rspTagOut !== '0 || mem_rspInsLineOut !== '0 || imem_rdAddrOut !== '0) begin
      bad++;
      $display("FAIL reset_data: tag=%h line=%h addr=%h expected all 0", mem_rspTagOut, mem_rspInsLineOut, imem_rdAddrOut);
    end
    Rst = 1'b0;
    @(negedge Clock);
  endtask

  task automatic test_basic();
    int unsigned r0;
    int k;
    bit got;
    mem[32'h100] = 32'hA0;
    mem[32'h104] = 32'hA1;
    mem[32'h108] = 32'hA2;
    mem[32'h10C] = 32'hA3;
    set_timing(1, 0, 0, 0, 0);
    r0 = reads;
    got = 1'b0;
    k = 0;
    mem_reqTagIn = 28'h0000010;
    mem_reqTagValidIn = 1'b1;
    while (!got && k < 20) begin
      @(negedge Clock);
      k++;
      if (k <= 4) begin
        total++;
        if (imem_rdReqOut !== 1'b1 || imem_rdAddrOut !== 32'h100 + 32'(4 * (k - 1))) begin
          bad++;
          $display("FAIL basic_read%0d: req=%b addr=%h expected req=1 addr=%h", k, imem_rdReqOut,
                   imem_rdAddrOut, 32'h100 + 32'(4 * (k - 1)));
        end
      end else if (k == 5) begin
        total++;
        if (imem_rdReqOut !== 1'b0) begin
          bad++;
          $display("FAIL basic_no_extra_read: req=%b expected 0", imem_rdReqOut);
        end
      end
      if (mem_rspInsLineValidOut === 1'b1) got = 1'b1;
    end
    mem_reqTagValidIn = 1'b0;
    total++;
    if (!got || k != 6) begin
      bad++;
      $display("FAIL basic_latency: response at T+%0d (seen=%0b) expected T+6", k, got);
    end
    total++;
    if (mem_rspTagOut !== 28'h0000010 || mem_rspInsLineOut !== BASIC_LINE) begin
      bad++;
      $display("FAIL basic_line: tag=%h line=%h expected tag=0000010 line=%h", mem_rspTagOut, mem_rspInsLineOut, BASIC_LINE);
    end
    @(negedge Clock);
    total++;
    if (mem_rspInsLineValidOut !== 1'b0 || busy !== 1'b1 || mem_rspInsLineOut !== BASIC_LINE) begin
      bad++;
      $display("FAIL basic_hold: valid=%b busy=%b line=%h expected valid=0 busy=1 line held", mem_rspInsLineValidOut, busy, mem_rspInsLineOut);
    end
    @(negedge Clock);
    total++;
    if (busy !== 1'b0 || reads - r0 != 4) begin
      bad++;
      $display("FAIL basic_idle: busy=%b reads=%0d expected busy=0 reads=4", busy, reads - r0);
    end
  endtask

  task automatic test_var_latency();
    int unsigned r0, p0;
    bit got;
    set_timing(1, 1, 3, 0, 2);
    r0 = reads;
    p0 = rsp_pulses;
    mem_reqTagIn = 28'h0000011;
    mem_reqTagValidIn = 1'b1;
    wait_rsp(40, got);
    mem_reqTagValidIn = 1'b0;
    total++;
    if (!got || cyc != last_ret_cyc + 1) begin
      bad++;
      $display("FAIL var_timing: seen=%0b rsp_cycle=%0d expected %0d", got, cyc, last_ret_cyc + 1);
    end
    total++;
    if (mem_rspTagOut !== 28'h0000011 || mem_rspInsLineOut !== exp_line(28'h0000011)) begin
      bad++;
      $display("FAIL var_line: tag=%h line=%h expected tag=0000011 line=%h", mem_rspTagOut, mem_rspInsLineOut, exp_line(28'h0000011));
    end
    repeat (2) @(negedge Clock);
    total++;
    if (reads - r0 != 4 || rsp_pulses - p0 != 1) begin
      bad++;
      $display("FAIL var_counts: reads=%0d pulses=%0d expected reads=4 pulses=1", reads - r0, rsp_pulses - p0);
    end
  endtask

  task automatic test_held_req();
    int unsigned r0, t1, t2;
    bit got;
    set_timing(1, 0, 0, 0, 0);
    r0 = reads;
    mem_reqTagIn = 28'h0000012;
    mem_reqTagValidIn = 1'b1;
    wait_rsp(20, got);
    t1 = cyc;
    total++;
    if (!got || mem_rspTagOut !== 28'h0000012) begin
      bad++;
      $display("FAIL held_first: seen=%0b tag=%h expected tag=0000012", got, mem_rspTagOut);
    end
    @(negedge Clock);
    total++;
    if (busy !== 1'b1 || imem_rdReqOut !== 1'b0 || mem_rspInsLineValidOut !== 1'b0) begin
      bad++;
      $display("FAIL held_hold: busy=%b rdreq=%b valid=%b expected 1 0 0", busy, imem_rdReqOut, mem_rspInsLineValidOut);
    end
    @(negedge Clock);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL held_idle: busy=%b expected 0", busy);
    end
    wait_rsp(20, got);
    t2 = cyc;
    mem_reqTagValidIn = 1'b0;
    total++;
    if (!got || t2 - t1 != 8) begin
      bad++;
      $display("FAIL held_period: seen=%0b spacing=%0d expected 8", got, t2 - t1);
    end
    total++;
    if (mem_rspTagOut !== 28'h0000012 || mem_rspInsLineOut !== exp_line(28'h0000012)) begin
      bad++;
      $display("FAIL held_second: tag=%h line=%h expected tag=0000012 line=%h", mem_rspTagOut, mem_rspInsLineOut, exp_line(28'h0000012));
    end
    repeat (2) @(negedge Clock);
    total++;
    if (reads - r0 != 8) begin
      bad++;
      $display("FAIL held_reads: reads=%0d expected 8", reads - r0);
    end
  endtask

  task automatic test_tag_change();
    int base;
    bit got;
    set_timing(1, 0, 0, 0, 0);
    mem_reqTagIn = 28'h0000010;
    mem_reqTagValidIn = 1'b1;
    repeat (2) @(negedge Clock);
    mem_reqTagIn = 28'h0000020;
    wait_rsp(30, got);
    total++;
    if (!got || mem_rspTagOut !== 28'h0000010 || mem_rspInsLineOut !== BASIC_LINE) begin
      bad++;
      $display("FAIL chg_first: seen=%0b tag=%h line=%h expected tag=0000010 line=%h", got, mem_rspTagOut, mem_rspInsLineOut, BASIC_LINE);
    end
    base = addr_log.size();
    wait_rsp(30, got);
    mem_reqTagValidIn = 1'b0;
    total++;
    if (!got || mem_rspTagOut !== 28'h0000020 || mem_rspInsLineOut !== exp_line(28'h0000020)) begin
      bad++;
      $display("FAIL chg_second: seen=%0b tag=%h line=%h expected tag=0000020 line=%h", got, mem_rspTagOut, mem_rspInsLineOut, exp_line(28'h0000020));
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (addr_log.size() <= base + i || addr_log[base + i] !== 32'h200 + 32'(4 * i)) begin
        bad++;
        $display("FAIL chg_addr%0d: logged=%0d reads, expected address %h", i, addr_log.size() - base, 32'h200 + 32'(4 * i));
      end
    end
    repeat (2) @(negedge Clock);
  endtask

  task automatic test_reset_mid();
    int unsigned r0, p0;
    int k;
    bit got;
    set_timing(3, 0, 0, 0, 0);
    r0 = rets;
    mem_reqTagIn = 28'h0000040;
    mem_reqTagValidIn = 1'b1;
    k = 0;
    while (rets - r0 < 2 && k < 30) begin
      @(negedge Clock);
      k++;
    end
    total++;
    if (rets - r0 != 2 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_setup: returns=%0d busy=%b expected 2 and 1", rets - r0, busy);
    end
    Rst = 1'b1;
    mem_reqTagValidIn = 1'b0;
    @(negedge Clock);
    total++;
    if ({mem_rspInsLineValidOut, imem_rdReqOut, busy} !== 3'b000 || mem_rspTagOut !== '0 ||
        mem_rspInsLineOut !== '0 || imem_rdAddrOut !== '0) begin
      bad++;
      $display("FAIL rstmid_outputs: v/rq/busy=%b tag=%h line=%h addr=%h expected all 0",
               {mem_rspInsLineValidOut, imem_rdReqOut, busy}, mem_rspTagOut, mem_rspInsLineOut, imem_rdAddrOut);
    end
    Rst = 1'b0;
    p0 = rsp_pulses;
    k = 0;
    while (pq.size() > 0 && k < 20) begin
      @(negedge Clock);
      k++;
    end
    repeat (3) @(negedge Clock);
    total++;
    if (rets - r0 != 4 || rsp_pulses != p0 || busy !== 1'b0 || mem_rspInsLineOut !== '0) begin
      bad++;
      $display("FAIL rstmid_stray: returns=%0d pulses=%0d busy=%b line=%h expected 4 0 0 0", rets - r0, rsp_pulses - p0, busy, mem_rspInsLineOut);
    end
    set_timing(1, 0, 0, 0, 0);
    mem_reqTagIn = 28'h0000030;
    mem_reqTagValidIn = 1'b1;
    wait_rsp(20, got);
    mem_reqTagValidIn = 1'b0;
    total++;
    if (!got || mem_rspTagOut !== 28'h0000030 || mem_rspInsLineOut !== exp_line(28'h0000030)) begin
      bad++;
      $display("FAIL rstmid_fresh: seen=%0b tag=%h line=%h expected tag=0000030 line=%h", got, mem_rspTagOut, mem_rspInsLineOut, exp_line(28'h0000030));
    end
    repeat (2) @(negedge Clock);
  endtask

  task automatic test_spurious();
    int unsigned p0;
    bit got;
    p0 = rsp_pulses;
    inj_data = 32'h0000DEAD;
    inj_req++;
    repeat (3) @(negedge Clock);
    total++;
    if (rsp_pulses != p0 || busy !== 1'b0 || mem_rspInsLineOut !== exp_line(28'h0000030)) begin
      bad++;
      $display("FAIL spur_idle: pulses=%0d busy=%b line=%h expected 0 0 %h", rsp_pulses - p0, busy, mem_rspInsLineOut, exp_line(28'h0000030));
    end
    mem_reqTagIn = 28'h0000050;
    mem_reqTagValidIn = 1'b1;
    wait_rsp(20, got);
    mem_reqTagValidIn = 1'b0;
    total++;
    if (!got || mem_rspTagOut !== 28'h0000050 || mem_rspInsLineOut !== exp_line(28'h0000050)) begin
      bad++;
      $display("FAIL spur_next: seen=%0b tag=%h line=%h expected tag=0000050 line=%h", got, mem_rspTagOut, mem_rspInsLineOut, exp_line(28'h0000050));
    end
    repeat (2) @(negedge Clock);
  endtask

  task automatic test_random();
    int unsigned r0;
    logic [TW-1:0] tag;
    bit got;
    for (int it = 0; it < 10; it++) begin
      tag = TW'($urandom);
      set_timing($urandom_range(1, 4), $urandom_range(0, 2), $urandom_range(0, 2),
                 $urandom_range(0, 2), $urandom_range(0, 2));
      r0 = reads;
      mem_reqTagIn = tag;
      mem_reqTagValidIn = 1'b1;
      wait_rsp(60, got);
      mem_reqTagValidIn = 1'b0;
      total++;
      if (!got || cyc != last_ret_cyc + 1 || mem_rspTagOut !== tag || mem_rspInsLineOut !== exp_line(tag)) begin
        bad++;
        $display("FAIL rand%0d: seen=%0b tag=%h line=%h expected tag=%h line=%h", it, got, mem_rspTagOut,
                 mem_rspInsLineOut, tag, exp_line(tag));
      end
      repeat (2) @(negedge Clock);
      total++;
      if (reads - r0 != 4 || busy !== 1'b0) begin
        bad++;
        $display("FAIL rand%0d_reads: reads=%0d busy=%b expected 4 and 0", it, reads - r0, busy);
      end
    end
  endtask

  initial begin
    Rst = 1'b1;
    mem_reqTagIn = '0;
    mem_reqTagValidIn = 1'b0;
    test_reset();
    test_basic();
    test_var_latency();
    test_held_req();
    test_tag_change();
    test_reset_mid();
    test_spurious();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
